// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants for the PS/2 key tracker: protocol bytes,
// FSM state encodings and small helpers.
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR_LO = 8'h00;
    localparam logic [7:0] PS2_ERR_HI = 8'hFF;

    localparam logic [7:0] KEY_W    = 8'h1D;
    localparam logic [7:0] KEY_S    = 8'h1B;
    localparam logic [7:0] KEY_UP   = 8'h75;
    localparam logic [7:0] KEY_DOWN = 8'h72;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    // Pause is E1 followed by seven more bytes that carry no key info
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_selftest(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR_LO) ||
               (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_code_match.sv
// Priority matcher: finds the lowest-index tracked key whose
// scan code and extended flag equal the completed sequence.
module ps2_code_match
    import ps2_key_tracker_pkg::*;
#(
    parameter int                    NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES = {8'h72, 8'h75, 8'h1B, 8'h1D},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT   = 4'b1100,
    parameter int                    IDX_W     = idx_w(NUM_KEYS)
) (
    input  logic [7:0]       code,
    input  logic             ext,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // walk downward so the lowest matching index is written last
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEY_CODES[8*i +: 8] == code && KEY_EXT[i] == ext) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the PS/2 byte stream into per-key held state, a one-cycle
// change event stream and last-sequence debug registers.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                    NUM_KEYS       = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES      = {8'h72, 8'h75, 8'h1B, 8'h1D},
    parameter logic [NUM_KEYS-1:0]   KEY_EXT        = 4'b1100,
    parameter int                    TIMEOUT_CYCLES = 100_000
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic                          clear,
    input  logic [7:0]                    ps2_data,
    input  logic                          ps2_data_en,
    output logic [NUM_KEYS-1:0]           key_down,
    output logic                          event_valid,
    output logic [idx_w(NUM_KEYS)-1:0]    event_idx,
    output logic                          event_make,
    output logic [7:0]                    last_code,
    output logic                          last_ext,
    output logic                          last_break,
    output logic                          timeout_err
);

    localparam int IDX_W = idx_w(NUM_KEYS);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0]          state_q, state_d;
    logic [2:0]          skip_q, skip_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_KEYS-1:0] key_down_q, key_down_d;
    logic                ev_valid_q, ev_valid_d;
    logic [IDX_W-1:0]    ev_idx_q, ev_idx_d;
    logic                ev_make_q, ev_make_d;
    logic [7:0]          last_code_q, last_code_d;
    logic                last_ext_q, last_ext_d;
    logic                last_brk_q, last_brk_d;
    logic                tmo_err_q, tmo_err_d;

    logic             seq_ext;
    logic             seq_brk;
    logic             complete;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;

    assign seq_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign seq_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    ps2_code_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES),
        .KEY_EXT   (KEY_EXT),
        .IDX_W     (IDX_W)
    ) u_match (
        .code (ps2_data),
        .ext  (seq_ext),
        .hit  (hit),
        .idx  (hit_idx)
    );

    // does the current byte finish a make/break sequence?
    always_comb begin
        complete = 1'b0;
        case (state_q)
            ST_IDLE: complete = (ps2_data != PS2_EXT) &&
                                (ps2_data != PS2_BRK) &&
                                (ps2_data != PS2_PAUSE) &&
                                !is_selftest(ps2_data);
            ST_EXT:     complete = (ps2_data != PS2_BRK);
            ST_BRK:     complete = 1'b1;
            ST_EXT_BRK: complete = 1'b1;
            default:    complete = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        skip_d      = skip_q;
        tmo_d       = tmo_q;
        key_down_d  = key_down_q;
        ev_valid_d  = 1'b0;
        ev_idx_d    = ev_idx_q;
        ev_make_d   = ev_make_q;
        last_code_d = last_code_q;
        last_ext_d  = last_ext_q;
        last_brk_d  = last_brk_q;
        tmo_err_d   = 1'b0;

        if (clear) begin
            state_d     = ST_IDLE;
            skip_d      = '0;
            tmo_d       = '0;
            key_down_d  = '0;
            ev_idx_d    = '0;
            ev_make_d   = 1'b0;
            last_code_d = '0;
            last_ext_d  = 1'b0;
            last_brk_d  = 1'b0;
        end else if (ps2_data_en) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == PS2_EXT) begin
                        state_d = ST_EXT;
                    end else if (ps2_data == PS2_BRK) begin
                        state_d = ST_BRK;
                    end else if (ps2_data == PS2_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = PAUSE_TAIL;
                    end
                end
                ST_EXT: begin
                    if (ps2_data == PS2_BRK) state_d = ST_EXT_BRK;
                end
                ST_BRK, ST_EXT_BRK: ;
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (complete) begin
                state_d     = ST_IDLE;
                last_code_d = ps2_data;
                last_ext_d  = seq_ext;
                last_brk_d  = seq_brk;
                if (hit && !seq_brk && !key_down_q[hit_idx]) begin
                    key_down_d[hit_idx] = 1'b1;
                    ev_valid_d = 1'b1;
                    ev_idx_d   = hit_idx;
                    ev_make_d  = 1'b1;
                end else if (hit && seq_brk && key_down_q[hit_idx]) begin
                    key_down_d[hit_idx] = 1'b0;
                    ev_valid_d = 1'b1;
                    ev_idx_d   = hit_idx;
                    ev_make_d  = 1'b0;
                end
            end
        end else if (state_q != ST_IDLE) begin
            // a stalled multi-byte sequence is abandoned, held keys stay held
            if (tmo_q == TMO_LAST) begin
                state_d   = ST_IDLE;
                skip_d    = '0;
                tmo_d     = '0;
                tmo_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            skip_q      <= '0;
            tmo_q       <= '0;
            key_down_q  <= '0;
            ev_valid_q  <= 1'b0;
            ev_idx_q    <= '0;
            ev_make_q   <= 1'b0;
            last_code_q <= '0;
            last_ext_q  <= 1'b0;
            last_brk_q  <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            tmo_q       <= tmo_d;
            key_down_q  <= key_down_d;
            ev_valid_q  <= ev_valid_d;
            ev_idx_q    <= ev_idx_d;
            ev_make_q   <= ev_make_d;
            last_code_q <= last_code_d;
            last_ext_q  <= last_ext_d;
            last_brk_q  <= last_brk_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign key_down    = key_down_q;
    assign event_valid = ev_valid_q;
    assign event_idx   = ev_idx_q;
    assign event_make  = ev_make_q;
    assign last_code   = last_code_q;
    assign last_ext    = last_ext_q;
    assign last_break  = last_brk_q;
    assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios plus
// random key sequences against a sequence-level reference model.
module tb_ps2_key_tracker;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic [7:0] data = 8'h00;

    logic [3:0] key_down;
    logic       event_valid;
    logic [1:0] event_idx;
    logic       event_make;
    logic [7:0] last_code;
    logic       last_ext;
    logic       last_break;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail = 0;
    int ev_q[$];
    int tmo_pulses = 0;
    logic [7:0] seq_q[$];

    logic [3:0] m_down;
    logic [7:0] m_code;
    logic       m_ext;
    logic       m_brk;

    logic [7:0] m_keys [4] = '{8'h1D, 8'h1B, 8'h75, 8'h72};
    logic       m_kext [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] pool   [7] = '{8'h1D, 8'h1B, 8'h75, 8'h72, 8'h14, 8'h29, 8'h5A};
    logic [7:0] selft  [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    always #5 clk = ~clk;

    ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .clear       (clear),
        .ps2_data    (data),
        .ps2_data_en (en),
        .key_down    (key_down),
        .event_valid (event_valid),
        .event_idx   (event_idx),
        .event_make  (event_make),
        .last_code   (last_code),
        .last_ext    (last_ext),
        .last_break  (last_break),
        .timeout_err (timeout_err)
    );

    always @(posedge clk) begin
        #1;
        if (event_valid === 1'b1) ev_q.push_back(int'({event_idx, event_make}));
        if (timeout_err === 1'b1) tmo_pulses++;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        data = b;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_seq(input int maxgap);
        foreach (seq_q[i]) send_byte(seq_q[i], $urandom_range(0, maxgap));
        @(negedge clk);
    endtask

    // sequence-level model: prefixes decide ext/brk, last byte is the code
    task automatic model_apply(output int ev);
        int i;
        logic e, k;
        logic [7:0] c;
        ev = -1;
        foreach (selft[j]) if (seq_q[0] == selft[j]) return;
        if (seq_q[0] == 8'hE1) return;
        i = 0; e = 0; k = 0;
        if (seq_q[i] == 8'hE0) begin e = 1; i++; end
        if (seq_q[i] == 8'hF0) begin k = 1; i++; end
        c = seq_q[i];
        m_code = c; m_ext = e; m_brk = k;
        for (int j = 0; j < 4; j++) begin
            if (m_keys[j] == c && m_kext[j] == e) begin
                if (!k && !m_down[j]) begin m_down[j] = 1; ev = 2*j + 1; end
                else if (k && m_down[j]) begin m_down[j] = 0; ev = 2*j; end
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({key_down, event_valid, event_idx, event_make, timeout_err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b exp=0", {key_down, event_valid, event_idx, event_make, timeout_err});
        end
        n_checks++;
        if ({last_code, last_ext, last_break} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_last got=%h exp=0", {last_code, last_ext, last_break});
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_make_break;
        ev_q.delete();
        seq_q = '{8'h1D};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0001) begin
            n_fail++; $display("FAIL mb_make key_down=%b exp=0001", key_down);
        end
        seq_q = '{8'hF0, 8'h1D};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0000) begin
            n_fail++; $display("FAIL mb_break key_down=%b exp=0000", key_down);
        end
        n_checks++;
        if (ev_q.size() != 2 || ev_q[0] != 1 || ev_q[1] != 0) begin
            n_fail++; $display("FAIL mb_events n=%0d exp=2 (1,0)", ev_q.size());
        end
        n_checks++;
        if ({last_code, last_ext, last_break} !== {8'h1D, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL mb_last got=%h/%b/%b exp=1d/0/1", last_code, last_ext, last_break);
        end
    endtask

    task automatic test_extended;
        ev_q.delete();
        seq_q = '{8'hE0, 8'h75};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0100 || last_ext !== 1'b1) begin
            n_fail++; $display("FAIL ext_make key_down=%b ext=%b exp=0100/1", key_down, last_ext);
        end
        seq_q = '{8'hE0, 8'hF0, 8'h75};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0000 || ev_q.size() != 2 || ev_q[0] != 5 || ev_q[1] != 4) begin
            n_fail++; $display("FAIL ext_break key_down=%b nev=%0d exp=0000/2", key_down, ev_q.size());
        end
        ev_q.delete();
        seq_q = '{8'h75};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0000 || ev_q.size() != 0 || last_ext !== 1'b0) begin
            n_fail++; $display("FAIL ext_bare key_down=%b nev=%0d ext=%b exp=0000/0/0", key_down, ev_q.size(), last_ext);
        end
    endtask

    task automatic test_typematic;
        ev_q.delete();
        seq_q = '{8'h1D, 8'h1D, 8'h1D, 8'h1D, 8'h1D};
        send_seq(1);
        n_checks++;
        if (key_down !== 4'b0001 || ev_q.size() != 1 || ev_q[0] != 1) begin
            n_fail++; $display("FAIL typematic key_down=%b nev=%0d exp=0001/1", key_down, ev_q.size());
        end
        ev_q.delete();
        seq_q = '{8'hF0, 8'h1B};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0001 || ev_q.size() != 0 || last_code !== 8'h1B || last_break !== 1'b1) begin
            n_fail++; $display("FAIL brk_released key_down=%b nev=%0d code=%h exp=0001/0/1b", key_down, ev_q.size(), last_code);
        end
    endtask

    task automatic test_timeout;
        int n;
        tmo_pulses = 0;
        ev_q.delete();
        send_byte(8'hE0, 0);
        n = 0;
        while (timeout_err !== 1'b1 && n < T + 5) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n < T - 1 || n > T + 1) begin
            n_fail++; $display("FAIL tmo_latency got=%0d exp=%0d", n, T);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (tmo_pulses != 1 || key_down !== 4'b0001) begin
            n_fail++; $display("FAIL tmo_pulse pulses=%0d key_down=%b exp=1/0001", tmo_pulses, key_down);
        end
        seq_q = '{8'h72};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0001 || ev_q.size() != 0 || last_code !== 8'h72 || last_ext !== 1'b0) begin
            n_fail++; $display("FAIL tmo_after key_down=%b nev=%0d code=%h ext=%b exp=0001/0/72/0", key_down, ev_q.size(), last_code, last_ext);
        end
    endtask

    task automatic test_pause;
        seq_q = '{8'hF0, 8'h1D};
        send_seq(0);
        ev_q.delete();
        seq_q = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        send_seq(2);
        n_checks++;
        if (ev_q.size() != 0 || key_down !== 4'b0000 ||
            {last_code, last_ext, last_break} !== {8'h1D, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL pause nev=%0d key_down=%b last=%h/%b/%b exp=0/0000/1d/0/1", ev_q.size(), key_down, last_code, last_ext, last_break);
        end
        seq_q = '{8'h1D};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0001 || ev_q.size() != 1) begin
            n_fail++; $display("FAIL pause_next key_down=%b nev=%0d exp=0001/1", key_down, ev_q.size());
        end
    endtask

    task automatic test_reset_clear;
        seq_q = '{8'h1B};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0011) begin
            n_fail++; $display("FAIL rc_hold key_down=%b exp=0011", key_down);
        end
        send_byte(8'hE0, 0);
        send_byte(8'hF0, 0);
        @(posedge clk);
        #2 resetn = 1'b0;
        #2;
        n_checks++;
        if ({key_down, event_valid, last_code, last_ext, last_break, timeout_err} !== 15'd0) begin
            n_fail++; $display("FAIL rc_async key_down=%b last=%h exp=0", key_down, last_code);
        end
        #2 resetn = 1'b1;
        ev_q.delete();
        seq_q = '{8'h1B};
        send_seq(0);
        n_checks++;
        if (key_down !== 4'b0010 || ev_q.size() != 1 || ev_q[0] != 3) begin
            n_fail++; $display("FAIL rc_after key_down=%b nev=%0d exp=0010/1", key_down, ev_q.size());
        end
        ev_q.delete();
        @(negedge clk);
        clear = 1'b1; en = 1'b1; data = 8'h1D;
        @(negedge clk);
        clear = 1'b0; en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (key_down !== 4'b0000 || ev_q.size() != 0 || last_code !== 8'h00) begin
            n_fail++; $display("FAIL rc_clear key_down=%b nev=%0d code=%h exp=0000/0/00", key_down, ev_q.size(), last_code);
        end
    endtask

    task automatic test_random;
        int r, ev;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_down = '0; m_code = '0; m_ext = 0; m_brk = 0;
        tmo_pulses = 0;
        for (int it = 0; it < 80; it++) begin
            seq_q.delete();
            r = $urandom_range(0, 19);
            if (r == 0) begin
                seq_q.push_back(selft[$urandom_range(0, 5)]);
            end else if (r == 1) begin
                seq_q = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
            end else begin
                if ($urandom_range(0, 1) == 1) seq_q.push_back(8'hE0);
                if ($urandom_range(0, 1) == 1) seq_q.push_back(8'hF0);
                seq_q.push_back(pool[$urandom_range(0, 6)]);
            end
            ev_q.delete();
            send_seq(3);
            model_apply(ev);
            n_checks++;
            if (key_down !== m_down) begin
                n_fail++; $display("FAIL rnd_keys it=%0d got=%b exp=%b", it, key_down, m_down);
            end
            n_checks++;
            if ({last_code, last_ext, last_break} !== {m_code, m_ext, m_brk}) begin
                n_fail++; $display("FAIL rnd_last it=%0d got=%h/%b/%b exp=%h/%b/%b", it, last_code, last_ext, last_break, m_code, m_ext, m_brk);
            end
            n_checks++;
            if ((ev < 0 && ev_q.size() != 0) ||
                (ev >= 0 && (ev_q.size() != 1 || ev_q[0] != ev))) begin
                n_fail++; $display("FAIL rnd_event it=%0d nev=%0d exp_ev=%0d", it, ev_q.size(), ev);
            end
        end
        n_checks++;
        if (tmo_pulses != 0) begin
            n_fail++; $display("FAIL rnd_no_timeout got=%0d exp=0", tmo_pulses);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_make_break();
        test_extended();
        test_typematic();
        test_timeout();
        test_pause();
        test_reset_clear();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
